// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: time-shares one full_adder cell over WIDTH cycles.
// Optional SERIAL_ADD_SUB_EN macro adds a 'sub' port for two's-complement subtraction.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] psum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             accept_s;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;
  logic [WIDTH-1:0] psum_next_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Accept decision, operand preconditioning and partial-sum shift value
  always_comb begin
    accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    psum_next_s = {fa_sum_s, psum_r};
    b_load_s    = b;
    c_load_s    = cin;
`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so cout=1 means no borrow
    if (sub) begin
      b_load_s = ~b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b;
      c_load_s = cin;
    end
`endif
  end

  // Sequencer: load on accept, one bit per RUN cycle, publish result on last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      psum_r  <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b_load_s;
            psum_r  <= {(WIDTH-1){1'b0}};
            carry_r <= c_load_s;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          psum_r  <= psum_next_s[WIDTH-1:1];
          carry_r <= fa_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            sum_r   <= psum_next_s;
            cout_r  <= fa_cout_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Define SERIAL_ADD_SUB_EN to also exercise the subtract mode.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       cin_i;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub_i;
`endif

  int checks;
  int errors;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents a request on the next falling edge; returns at the falling edge
  // right after the accepting rising edge (first busy cycle), start low again.
  task automatic go(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a_i   = av;
    b_i   = bv;
    cin_i = cv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a_i   = 8'($urandom);
    b_i   = 8'($urandom);
    cin_i = 1'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b sum=%h cout=%0b expected all 0", busy, done, sum, cout);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== 11'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: busy=%0b done=%0b sum=%h cout=%0b expected all 0", i, busy, done, sum, cout);
      end
    end
  endtask

  task automatic test_basic();
    go(8'h0F, 8'h01, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
        errors++;
        $display("FAIL basic_run[%0d]: busy=%0b done=%0b sum=%h expected 1 0 00", n, busy, done, sum);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h10 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%0b busy=%0b sum=%h cout=%0b expected 1 0 10 0", done, busy, sum, cout);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10 || cout !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold: done=%0b busy=%0b sum=%h cout=%0b expected 0 0 10 0", done, busy, sum, cout);
      end
    end
  endtask

  task automatic test_carry();
    go(8'hFF, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_01: done=%0b sum=%h cout=%0b expected 1 00 1", done, sum, cout);
    end
    go(8'hFF, 8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'hFF || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ff_ff_1: done=%0b sum=%h cout=%0b expected 1 ff 1", done, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    go(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a_i   = 8'hAA;
    b_i   = 8'h55;
    cin_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    // Held through the final RUN edge (ignored) and the DONE edge (accepted)
    start = 1'b1;
    a_i   = 8'h80;
    b_i   = 8'h80;
    cin_i = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_mid_run: done=%0b busy=%0b sum=%h cout=%0b expected 1 0 46 0", done, busy, sum, cout);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h46) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%0b done=%0b sum=%h expected 1 0 46", busy, done, sum);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: done=%0b busy=%0b sum=%h cout=%0b expected 1 0 00 1", done, busy, sum, cout);
    end
  endtask

  task automatic test_reset_abort();
    go(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b done=%0b sum=%h cout=%0b expected all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL abort_discard: busy=%0b done=%0b sum=%h cout=%0b expected all 0", busy, done, sum, cout);
    end
    go(8'h03, 8'h04, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h07 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: done=%0b sum=%h cout=%0b expected 1 07 0", done, sum, cout);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic       cv [4];
    logic [7:0] es [4];
    logic       ec [4];
    av = '{8'h05, 8'h07, 8'h05, 8'h07};
    bv = '{8'h07, 8'h05, 8'h07, 8'h05};
    cv = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{8'hFE, 8'h02, 8'hFE, 8'h02};
    ec = '{1'b0, 1'b1, 1'b0, 1'b1};
    sub_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      go(av[k], bv[k], cv[k]);
      repeat (8) @(negedge clk);
      checks++;
      if (done !== 1'b1 || sum !== es[k] || cout !== ec[k]) begin
        errors++;
        $display("FAIL sub[%0d]: done=%0b sum=%h cout=%0b expected 1 %h %0b", k, done, sum, cout, es[k], ec[k]);
      end
    end
    sub_i = 1'b0;
    go(8'h05, 8'h07, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h0D || cout !== 1'b0) begin
      errors++;
      $display("FAIL sub0_add: done=%0b sum=%h cout=%0b expected 1 0d 0", done, sum, cout);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
`ifdef SERIAL_ADD_SUB_EN
    sub_i = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
